// File: rtl/dm_responder_pkg.sv
// Shared encodings and request record for the M-stage data-memory responder.
// Also holds the alignment rule so the FSM and any future users agree on it.
package dm_responder_pkg;

    typedef enum logic [1:0] {
        SIZE_W    = 2'b00,
        SIZE_H    = 2'b01,
        SIZE_B    = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } req_t;

    // The reserved size encoding behaves exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering for the data-memory responder: store byte enables and
// merged word, plus load extraction with sign/zero extension.
module dm_lane
    import dm_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [1:0]  offset,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] merged_word,
    output logic [31:0] load_word
);

    logic [31:0] lane_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Narrow store data is replicated across lanes so the enable alone picks it.
    always_comb begin
        byte_en   = 4'b1111;
        lane_data = wdata;
        case (size)
            SIZE_B: begin
                byte_en   = 4'b0001 << offset;
                lane_data = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                byte_en   = offset[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                lane_data = wdata;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[gi*8 +: 8] = byte_en[gi] ? lane_data[gi*8 +: 8]
                                                        : old_word[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        ld_byte   = old_word[{offset, 3'b000} +: 8];
        ld_half   = offset[1] ? old_word[31:16] : old_word[15:0];
        load_word = old_word;
        case (size)
            SIZE_B:  load_word = {{24{sext & ld_byte[7]}}, ld_byte};
            SIZE_H:  load_word = {{16{sext & ld_half[15]}}, ld_half};
            default: load_word = old_word;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// M-stage data-memory responder: one outstanding load/store, fixed access
// latency, one-cycle response strobe, alignment/range checking and store trace.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e      state_reg;
    logic [3:0]  cnt_reg;
    req_t        req_reg;
    logic [31:0] mem [DEPTH];

    logic        req_ready_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic [31:0] resp_rdata_reg;
    logic        busy_reg;

    // Store trace record, valid for the RESP cycle of a committed store.
    logic        trace_valid_reg;
    logic [31:0] trace_pc_reg;
    logic [31:0] trace_addr_reg;
    logic [31:0] trace_word_reg;

    logic                  accept;
    logic                  enter_resp;
    req_t                  cur;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic                  cur_err;
    logic [31:0]           old_word;
    logic [3:0]            byte_en;
    logic [31:0]           merged_word;
    logic [31:0]           load_word;

    assign accept = (state_reg == ST_IDLE) && req_ready_reg && req_valid;

    // With LATENCY=1 the commit coincides with the accept edge, so the live
    // inputs must feed the datapath while idle; otherwise the latched copy does.
    always_comb begin
        cur = req_reg;
        if (state_reg == ST_IDLE) begin
            cur.we    = req_we;
            cur.size  = req_size;
            cur.sext  = req_sext;
            cur.addr  = req_addr;
            cur.wdata = req_wdata;
            cur.pc    = req_pc;
        end
    end

    assign enter_resp = (accept && (LATENCY == 1)) ||
                        ((state_reg == ST_WAIT) && (cnt_reg == 4'd1));

    assign cur_idx  = cur.addr[ADDR_WIDTH+1:2];
    assign cur_err  = is_misaligned(cur.size, cur.addr[1:0]) || (|cur.addr[31:ADDR_WIDTH+2]);
    assign old_word = mem[cur_idx];

    dm_lane u_lane (
        .size        (cur.size),
        .sext        (cur.sext),
        .offset      (cur.addr[1:0]),
        .old_word    (old_word),
        .wdata       (cur.wdata),
        .byte_en     (byte_en),
        .merged_word (merged_word),
        .load_word   (load_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            req_reg         <= '0;
            req_ready_reg   <= 1'b0;
            resp_valid_reg  <= 1'b0;
            resp_err_reg    <= 1'b0;
            resp_rdata_reg  <= '0;
            busy_reg        <= 1'b0;
            trace_valid_reg <= 1'b0;
            trace_pc_reg    <= '0;
            trace_addr_reg  <= '0;
            trace_word_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            resp_valid_reg  <= 1'b0;
            resp_err_reg    <= 1'b0;
            resp_rdata_reg  <= '0;
            trace_valid_reg <= 1'b0;

            if (enter_resp) begin
                resp_valid_reg <= 1'b1;
                resp_err_reg   <= cur_err;
                resp_rdata_reg <= (cur.we || cur_err) ? 32'd0 : load_word;
                if (cur.we && !cur_err) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byte_en[b]) begin
                            mem[cur_idx][b*8 +: 8] <= merged_word[b*8 +: 8];
                        end
                    end
                    trace_valid_reg <= 1'b1;
                    trace_pc_reg    <= cur.pc;
                    trace_addr_reg  <= {cur.addr[31:2], 2'b00};
                    trace_word_reg  <= merged_word;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        req_reg       <= cur;
                        busy_reg      <= 1'b1;
                        req_ready_reg <= 1'b0;
                        if (LATENCY == 1) begin
                            state_reg <= ST_RESP;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= CNT_LOAD;
                        end
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_reg     <= ST_IDLE;
                    busy_reg      <= 1'b0;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    busy_reg      <= 1'b0;
                    req_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: a LATENCY=2 and a LATENCY=1 instance checked
// against an arithmetic memory model with directed and random traffic.
module tb_dm_responder;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;

    logic        rdy0, rv0, err0, busy0;
    logic [31:0] rd0;
    logic        rdy1, rv1, err1, busy1;
    logic [31:0] rd1;
    logic        rdy, rv, err, busy;
    logic [31:0] rd;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          trace_cnt = 0;
    logic [31:0] tr_pc, tr_addr, tr_word;
    logic [31:0] mdl [1 << AW];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rdy0),
        .req_we(req_we), .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc), .resp_valid(rv0), .resp_rdata(rd0),
        .resp_err(err0), .busy(busy0)
    );

    dm_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rdy1),
        .req_we(req_we), .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc), .resp_valid(rv1), .resp_rdata(rd1),
        .resp_err(err1), .busy(busy1)
    );

    assign rdy  = sel ? rdy1  : rdy0;
    assign rv   = sel ? rv1   : rv0;
    assign err  = sel ? err1  : err0;
    assign busy = sel ? busy1 : busy0;
    assign rd   = sel ? rd1   : rd0;

    // Store trace printer; also records the last line for checking.
    always @(posedge clk) begin
        #1;
        if (sel ? dut1.trace_valid_reg : dut0.trace_valid_reg) begin
            tr_pc   = sel ? dut1.trace_pc_reg   : dut0.trace_pc_reg;
            tr_addr = sel ? dut1.trace_addr_reg : dut0.trace_addr_reg;
            tr_word = sel ? dut1.trace_word_reg : dut0.trace_word_reg;
            $display("@%08h: *%08h <= %08h", tr_pc, tr_addr, tr_word);
            trace_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic exp_err(input logic [1:0] size, input logic [31:0] addr);
        if ((addr >> 2) >= (32'd1 << AW)) return 1'b1;
        if (size == 2'd1) return (addr % 2) != 0;
        if (size == 2'd2) return 1'b0;
        return (addr % 4) != 0;
    endfunction

    task automatic do_reset();
        req_valid = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, rdy}, 0);
        check("rst_valid", {31'd0, rv}, 0);
        check("rst_busy",  {31'd0, busy}, 0);
        check("rst_err",   {31'd0, err}, 0);
        check("rst_rdata", rd, 0);
        reset = 1'b0;
        foreach (mdl[i]) mdl[i] = '0;
    endtask

    // One request end to end; poke keeps a conflicting store on the bus while busy.
    task automatic xact(input logic we, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] pc, input bit poke);
        int unsigned widx;
        int          sh, n, k, tc0;
        logic        e, bad_busy;
        logic [31:0] mask, data, v, exp_rd, exp_word;

        e        = exp_err(size, addr);
        widx     = addr >> 2;
        sh       = int'(addr[1:0]) * 8;
        exp_rd   = '0;
        exp_word = '0;
        if (!e) begin
            if (we) begin
                if (size == 2'd2)      begin mask = 32'hFF << sh;   data = (wdata & 32'hFF) << sh;   end
                else if (size == 2'd1) begin mask = 32'hFFFF << sh; data = (wdata & 32'hFFFF) << sh; end
                else                   begin mask = 32'hFFFF_FFFF;  data = wdata;                    end
                mdl[widx] = (mdl[widx] & ~mask) | (data & mask);
                exp_word  = mdl[widx];
            end else begin
                v = mdl[widx] >> sh;
                if (size == 2'd2)      exp_rd = sext ? {{24{v[7]}}, v[7:0]}   : {24'd0, v[7:0]};
                else if (size == 2'd1) exp_rd = sext ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
                else                   exp_rd = mdl[widx];
            end
        end

        tc0 = trace_cnt;
        n = 0;
        while (rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("ready_wait", {31'd0, n < 50}, 1);

        req_we = we; req_size = size; req_sext = sext;
        req_addr = addr; req_wdata = wdata; req_pc = pc;
        req_valid = 1'b1;
        @(negedge clk);
        if (poke) begin
            req_we = 1'b1; req_size = 2'd0; req_addr = {addr[31:2], 2'b00};
            req_wdata = ~wdata ^ 32'h5A5A_0F0F; req_pc = pc + 4;
        end else begin
            req_valid = 1'b0;
        end

        k = 1;
        bad_busy = 1'b0;
        while (rv !== 1'b1 && k < 40) begin
            if (busy !== 1'b1) bad_busy = 1'b1;
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b1) bad_busy = 1'b1;
        req_valid = 1'b0;
        check("latency", k, sel ? 1 : 2);
        check("busy_hold", {31'd0, bad_busy}, 0);
        check("resp_err", {31'd0, err}, {31'd0, e});
        check("resp_rdata", rd, exp_rd);

        @(negedge clk);
        check("strobe_len", {31'd0, rv}, 0);
        check("busy_off", {31'd0, busy}, 0);
        check("trace_lines", trace_cnt - tc0, (we && !e) ? 1 : 0);
        if (we && !e) begin
            check("trace_pc", tr_pc, pc);
            check("trace_addr", tr_addr, addr & 32'hFFFF_FFFC);
            check("trace_word", tr_word, exp_word);
        end
        $display("xact dut%0d we=%0d size=%0d sext=%0d addr=%08h wdata=%08h -> err=%0d rdata=%08h",
                 sel, we, size, sext, addr, wdata, err, rd);
    endtask

    task automatic rand_xact(input int count);
        logic [31:0] a;
        for (int i = 0; i < count; i++) begin
            a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0001_0000;
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 a, $urandom, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0);
        end
    endtask

    int acc_cyc[$];
    int tc_snap;
    bit seen_rv;

    initial begin
        sel = 1'b0; req_we = 0; req_size = 0; req_sext = 0;
        req_addr = 0; req_wdata = 0; req_pc = 0; req_valid = 0;
        do_reset();

        // Word store then load, byte/half lanes, misaligned store.
        xact(1, 2'd0, 0, 32'h10, 32'h1234_5678, 32'h3000, 0);
        xact(0, 2'd0, 0, 32'h10, 32'h0, 32'h3004, 0);
        xact(1, 2'd2, 0, 32'h13, 32'h0000_00AB, 32'h3008, 0);
        xact(0, 2'd2, 1, 32'h13, 32'h0, 32'h300C, 0);
        xact(0, 2'd2, 0, 32'h13, 32'h0, 32'h3010, 0);
        xact(0, 2'd1, 1, 32'h12, 32'h0, 32'h3014, 0);
        xact(1, 2'd0, 0, 32'h0C, 32'h55AA_33CC, 32'h3018, 0);
        xact(1, 2'd0, 0, 32'h0E, 32'hFFFF_FFFF, 32'h301C, 0);
        xact(0, 2'd0, 0, 32'h0C, 32'h0, 32'h3020, 0);

        // Conflicting request during WAIT must be ignored.
        xact(0, 2'd0, 0, 32'h10, 32'h0, 32'h3024, 1);
        xact(0, 2'd0, 0, 32'h10, 32'h0, 32'h3028, 0);

        // Continuous req_valid: accepts spaced LATENCY+1 apart.
        while (rdy !== 1'b1) @(negedge clk);
        req_we = 0; req_size = 0; req_addr = 32'h10; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy) acc_cyc.push_back(cyc);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("accept_count", {31'd0, acc_cyc.size() >= 4}, 1);
        for (int i = 1; i < acc_cyc.size(); i++) check("accept_gap", acc_cyc[i] - acc_cyc[i-1], 3);

        // Reset while a store waits.
        while (rdy !== 1'b1) @(negedge clk);
        tc_snap = trace_cnt;
        req_we = 1; req_size = 0; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF; req_pc = 32'h4000;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        foreach (mdl[i]) mdl[i] = '0;
        seen_rv = rv;
        repeat (4) begin @(negedge clk); seen_rv |= rv; end
        check("rst_no_resp", {31'd0, seen_rv}, 0);
        check("rst_no_trace", trace_cnt - tc_snap, 0);
        xact(0, 2'd0, 0, 32'h20, 32'h0, 32'h4004, 0);
        xact(0, 2'd0, 0, 32'h10, 32'h0, 32'h4008, 0);

        // Out of range.
        xact(0, 2'd0, 0, 32'h0000_4000, 32'h0, 32'h400C, 0);
        xact(1, 2'd2, 0, 32'h0000_4001, 32'h77, 32'h4010, 0);

        rand_xact(150);

        // LATENCY=1 instance.
        sel = 1'b1;
        do_reset();
        xact(1, 2'd0, 0, 32'h40, 32'hCAFE_F00D, 32'h100, 0);
        xact(0, 2'd1, 1, 32'h42, 32'h0, 32'h104, 0);
        xact(0, 2'd1, 0, 32'h41, 32'h0, 32'h108, 0);
        rand_xact(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder for the pipeline's M-stage data-memory port.
- Accepts one load or store request at a time over a valid/ready handshake. Models configurable access latency, then returns read data or a store acknowledge on a one-cycle response strobe.
- Performs byte/half/word lane handling, load extension, misalignment detection and the store trace log.
- The CPU side stalls M while a request is outstanding.

Parameters:
- ADDR_WIDTH, 12, word-address bits; array depth = 2**ADDR_WIDTH words.
- LATENCY, 2, cycles from request acceptance to response strobe; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 half, 10 byte; 11 is reserved and treated as word.
- req_sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_pc  in  32  PC of the issuing instruction, used for the trace log.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or out-of-range address.
- busy  out  1  request outstanding; the CPU uses it as the M-stage stall.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
- Reset effects: FSM goes to IDLE, latency counter cleared, every array word cleared to 0.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch we/size/sext/addr/wdata/pc, load counter with LATENCY-1, go to WAIT (or to RESP directly if LATENCY=1). busy=1 from the next cycle.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0, busy deasserts at the same edge that leaves RESP. Next state is IDLE. A new request is acceptable in the cycle after RESP (no back-to-back overlap).
- Latency: response strobe LATENCY cycles after the accept edge; minimum turnaround is LATENCY+1 cycles per request.
- Store commit: array write happens on the edge entering RESP. Lane enables come from addr[1:0]:
  - byte: lane = addr[1:0], data = wdata[7:0].
  - half: lane = addr[1], data = wdata[15:0].
  - word: all lanes.
  - Untouched bytes are preserved.
- Store trace: at commit, log the line "@<pc>: *<word-aligned addr> <= <full merged word>", 8-hex-digit fields.
- Load read: word read at the transition into RESP. Extract byte/half by address offset, then sign- or zero-extend per the latched sext.
- Errors, reported in RESP with resp_err=1 and resp_rdata=0:
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr[31:2] >= 2**ADDR_WIDTH.
  - No array write occurs and no trace line is printed.
- Inputs are ignored while not in IDLE, even with req_valid=1.
- Reset asserted in WAIT or RESP: pending store is dropped (no write), no response, FSM returns to IDLE. Reset has priority over every other event.
- Address wrap: none; out-of-range is an error, never aliased.

Decomposition:
- Shared package/const include:
  - size encodings SIZE_W/SIZE_H/SIZE_B.
  - FSM state encodings ST_IDLE/ST_WAIT/ST_RESP.
- Sub-module dm_lane: combinational, computes byte-enable, merged store word and extended load data from (size, sext, offset, old word, wdata).
- FSM, counter and array stay in dm_responder.

Test Plan:
1. Word store then load, LATENCY=2:
   - Store addr 0x10, wdata 0x12345678 at pc 0x3000 -> resp_valid 2 cycles after accept, resp_err=0, log "@00003000: *00000010 <= 12345678".
   - Load 0x10 -> resp_rdata 0x12345678.
2. Byte/half lanes:
   - Over word 0x12345678 at 0x10, store byte 0xAB at 0x13 -> word becomes 0xAB345678.
   - Load byte 0x13 with sext=1 -> 0xFFFFFFAB; with sext=0 -> 0x000000AB.
   - Load half 0x12 with sext=1 -> 0xFFFFAB34.
3. Misaligned: word store to 0x0E -> resp_err=1, resp_rdata=0, no log line, later word load of 0x0C returns its prior value unchanged.
4. Handshake:
   - req_valid held high continuously -> accepts spaced exactly LATENCY+1 cycles apart.
   - busy high from the cycle after accept through the RESP cycle.
   - A differing request presented during WAIT is ignored.
5. Reset mid-op: assert reset in WAIT of a store to 0x20 -> no resp_valid, no log, subsequent load of 0x20 returns 0.
6. Range and latency:
   - Load 0x00004000 with ADDR_WIDTH=12 -> resp_err=1.
   - With LATENCY=1 -> resp_valid on the cycle directly after accept.
